// File: rtl/booth_wallace_8x8.sv
// Signed 8x8 -> 16-bit multiplier: radix-4 Booth recoding, Wallace carry-save tree, ripple CPA.
// Define BOOTH_WALLACE_PIPE_EN to register the two tree rows ahead of the CPA (latency 2).
module booth_wallace_8x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P
);

    // Sum of the -2^(9+2i) terms left over after inverting each partial-product sign bit.
    localparam logic [15:0] SIGN_COMP = 16'h5600;

    logic [8:0]  b_ext;
    logic [9:0]  a_ext;
    logic [3:0]  neg;
    logic [9:0]  pp [4];
    logic [15:0] row [5];
    logic [15:0] l1a_s, l1a_c, l1b_s, l1b_c;
    logic [15:0] l2_s, l2_c;
    logic [15:0] tree_s, tree_c;
    logic [15:0] cpa_a, cpa_b;
    logic [15:0] p_d, p_q;

    // Returns {carry, sum}; carries are pre-shifted and bit 15 carry-out is dropped.
    function automatic logic [31:0] fa_row(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z);
        logic [15:0] s;
        logic [15:0] m;
        s = x ^ y ^ z;
        m = (x & y) | (x & z) | (y & z);
        return {m[14:0], 1'b0, s};
    endfunction

    function automatic logic [31:0] ha_row(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] s;
        logic [15:0] m;
        s = x ^ y;
        m = x & y;
        return {m[14:0], 1'b0, s};
    endfunction

    always_comb begin : booth_pp
        logic [2:0] trip;
        logic       one;
        logic       two;
        logic [9:0] mag;
        b_ext = {B, 1'b0};
        a_ext = {A[7], A[7], A};
        neg   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            trip = b_ext[2*i +: 3];
            one  = trip[1] ^ trip[0];
            two  = (trip == 3'b100) || (trip == 3'b011);
            neg[i] = trip[2] & (one | two);
            mag = '0;
            if (one) begin
                mag = a_ext;
            end else if (two) begin
                mag = {a_ext[8:0], 1'b0};
            end
            pp[i] = mag ^ {10{neg[i]}};
        end
    end

    // Each negation's +1 rides in the free low column of the next row; the last one joins the constant.
    always_comb begin : pp_rows
        row[0] = {6'b0, ~pp[0][9], pp[0][8:0]};
        row[1] = {4'b0, ~pp[1][9], pp[1][8:0], 1'b0, neg[0]};
        row[2] = {2'b0, ~pp[2][9], pp[2][8:0], 1'b0, neg[1], 2'b0};
        row[3] = {~pp[3][9], pp[3][8:0], 1'b0, neg[2], 4'b0};
        row[4] = SIGN_COMP | {9'b0, neg[3], 6'b0};
    end

    always_comb begin : wallace
        {l1a_c, l1a_s}   = fa_row(row[0], row[1], row[2]);
        {l1b_c, l1b_s}   = ha_row(row[3], row[4]);
        {l2_c, l2_s}     = fa_row(l1a_s, l1a_c, l1b_s);
        {tree_c, tree_s} = fa_row(l2_s, l2_c, l1b_c);
    end

`ifdef BOOTH_WALLACE_PIPE_EN
    logic [15:0] stage_s_d, stage_s_q;
    logic [15:0] stage_c_d, stage_c_q;

    always_comb begin
        stage_s_d = tree_s;
        stage_c_d = tree_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_s_q <= '0;
            stage_c_q <= '0;
        end else begin
            stage_s_q <= stage_s_d;
            stage_c_q <= stage_c_d;
        end
    end

    always_comb begin
        cpa_a = stage_s_q;
        cpa_b = stage_c_q;
    end
`else
    always_comb begin
        cpa_a = tree_s;
        cpa_b = tree_c;
    end
`endif

    always_comb begin : cpa
        logic cy;
        cy  = 1'b0;
        p_d = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            p_d[k] = cpa_a[k] ^ cpa_b[k] ^ cy;
            cy     = (cpa_a[k] & cpa_b[k]) | (cpa_a[k] & cy) | (cpa_b[k] & cy);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign P = p_q;

endmodule

// File: tb/tb_booth_wallace_8x8.sv
// Directed and streaming checks for booth_wallace_8x8; latency follows BOOTH_WALLACE_PIPE_EN.
module tb_booth_wallace_8x8;

`ifdef BOOTH_WALLACE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;

    int n_vec;
    int n_err;

    booth_wallace_8x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit expired, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int r;
        r = int'($signed(a)) * int'($signed(b));
        return r[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        A = 8'd5;
        B = 8'hFD;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (P !== 16'h0000) begin
                $display("FAIL reset_hold cycle %0d: got %h expected 0000", i, P);
                n_err++;
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) tick();
        n_vec++;
        if (P !== 16'hFFF1) begin
            $display("FAIL reset_release: got %h expected fff1", P);
            n_err++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (P !== 16'h0000) begin
            $display("FAIL reset_async: got %h expected 0000", P);
            n_err++;
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0]  ta [8];
        logic [7:0]  tb [8];
        logic [15:0] te [8];
        ta = '{8'd5,  8'hF4, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h00};
        tb = '{8'hFD, 8'hF9, 8'h01, 8'h01, 8'h80, 8'h80, 8'h7F, 8'hC9};
        te = '{16'hFFF1, 16'h0054, 16'h007F, 16'hFF80,
               16'hC080, 16'h4000, 16'h3F01, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            A = ta[i];
            B = tb[i];
            for (int j = 0; j < LAT; j++) tick();
            n_vec++;
            if (P !== te[i]) begin
                $display("FAIL directed %0d (%h*%h): got %h expected %h", i, ta[i], tb[i], P, te[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [10];
        logic [7:0] vb [10];
        int r;
        int idx;
        for (int i = 0; i < 10; i++) begin
            r = $random;
            va[i] = r[7:0];
            vb[i] = r[15:8];
        end
        for (int n = 0; n < 10 + LAT - 1; n++) begin
            if (n < 10) begin
                A = va[n];
                B = vb[n];
            end
            tick();
            idx = n - LAT + 1;
            if (idx >= 0 && idx < 10) begin
                n_vec++;
                if (P !== ref_mul(va[idx], vb[idx])) begin
                    $display("FAIL back_to_back %0d (%h*%h): got %h expected %h",
                             idx, va[idx], vb[idx], P, ref_mul(va[idx], vb[idx]));
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] pair;
        logic [15:0] chk;
        for (int n = 0; n < 65536 + LAT - 1; n++) begin
            if (n < 65536) begin
                pair = n[15:0];
                A = pair[15:8];
                B = pair[7:0];
            end
            tick();
            if (n - LAT + 1 >= 0) begin
                chk = 16'(n - LAT + 1);
                n_vec++;
                if (P !== ref_mul(chk[15:8], chk[7:0])) begin
                    $display("FAIL exhaustive (%h*%h): got %h expected %h",
                             chk[15:8], chk[7:0], P, ref_mul(chk[15:8], chk[7:0]));
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        A = 8'd10;
        B = 8'd10;
        tick();
        A = 8'hFD;
        B = 8'd9;
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (P !== 16'h0000) begin
            $display("FAIL midstream_async: got %h expected 0000", P);
            n_err++;
        end
        tick();
        n_vec++;
        if (P !== 16'h0000) begin
            $display("FAIL midstream_held: got %h expected 0000", P);
            n_err++;
        end
        #2;
        rst_n = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            n_vec++;
            if (e < LAT) begin
                if (P !== 16'h0000) begin
                    $display("FAIL midstream_fill edge %0d: got %h expected 0000", e, P);
                    n_err++;
                end
            end else if (P !== 16'hFFE5) begin
                $display("FAIL midstream_first: got %h expected ffe5", P);
                n_err++;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        A = '0;
        B = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_exhaustive();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
